// File: rtl/ping_pong_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : ping_pong_buffer
//  Description : Dual-bank 32-bit word buffer between the DMA and the host
//                logic. The DMA side owns bank r_sel, the host side owns the
//                other bank; a DMA switch pulse swaps them. A host commit
//                raises dataReady and hands its word count to the DMA on the
//                next switch.
//                Optional macro PING_PONG_PARITY_EN adds an even-parity bit
//                per stored word and registered parity-error outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module ping_pong_buffer #(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          pushAddress,
    input  logic [31:0]          pushData,
    input  logic                 push,
    input  logic [31:0]          popAddress,
    output logic [31:0]          popData,
    input  logic                 switch,
    output logic                 dataReady,
    output logic [ADDR_BITS:0]   dmaWordCount,
    input  logic [ADDR_BITS-1:0] hostAddress,
    input  logic [31:0]          hostWriteData,
    input  logic                 hostWrite,
    output logic [31:0]          hostReadData,
    input  logic                 hostCommit,
    input  logic [ADDR_BITS:0]   hostWordCount,
    output logic                 hostOverrun
`ifdef PING_PONG_PARITY_EN
    ,
    output logic                 popParityError,
    output logic                 hostParityError
`endif
);

`ifdef PING_PONG_PARITY_EN
    localparam int c_STORE_W = 33;
`else
    localparam int c_STORE_W = 32;
`endif

    localparam logic [ADDR_BITS:0] c_DEPTH_COUNT = (ADDR_BITS + 1)'(DEPTH);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_nextState;
    logic                 r_sel;
    logic                 w_nextSel;
    logic [ADDR_BITS:0]   r_pendingCount;
    logic [ADDR_BITS:0]   w_nextPendingCount;
    logic [ADDR_BITS:0]   r_dmaWordCount;
    logic [ADDR_BITS:0]   w_nextDmaWordCount;
    logic                 r_hostOverrun;
    logic                 w_nextHostOverrun;
    logic [ADDR_BITS:0]   w_clampedCount;

    logic [ADDR_BITS-1:0] w_pushIdx;
    logic [ADDR_BITS-1:0] w_popIdx;
    logic [c_STORE_W-1:0] w_dmaStore;
    logic [c_STORE_W-1:0] w_hostStore;
    logic [1:0][c_STORE_W-1:0] w_popWord;
    logic [1:0][c_STORE_W-1:0] w_hostWord;

    // DMA addresses wrap within a bank; the upper bits are deliberately dropped.
    logic w_unusedAddrBits;
    assign w_unusedAddrBits = ^{pushAddress[31:ADDR_BITS], popAddress[31:ADDR_BITS]};

    assign w_pushIdx = pushAddress[ADDR_BITS-1:0];
    assign w_popIdx  = popAddress[ADDR_BITS-1:0];

`ifdef PING_PONG_PARITY_EN
    assign w_dmaStore  = {^pushData, pushData};
    assign w_hostStore = {^hostWriteData, hostWriteData};
`else
    assign w_dmaStore  = pushData;
    assign w_hostStore = hostWriteData;
`endif

    // Each bank has one write port, steered to the DMA or host side by r_sel.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [c_STORE_W-1:0] r_mem [DEPTH];
        logic                 w_dmaOwns;
        logic                 w_we;
        logic [ADDR_BITS-1:0] w_wAddr;
        logic [c_STORE_W-1:0] w_wData;

        assign w_dmaOwns = (r_sel == 1'(b));
        assign w_we      = w_dmaOwns ? push       : hostWrite;
        assign w_wAddr   = w_dmaOwns ? w_pushIdx  : hostAddress;
        assign w_wData   = w_dmaOwns ? w_dmaStore : w_hostStore;

        // Memory write; contents are not reset.
        always_ff @(posedge clock) begin
            if (w_we) begin
                r_mem[w_wAddr] <= w_wData;
            end
        end

        assign w_popWord[b]  = r_mem[w_popIdx];
        assign w_hostWord[b] = r_mem[hostAddress];
    end

    // Registered reads; sampling the old array contents gives read-before-write.
    always_ff @(posedge clock) begin
        if (reset) begin
            popData      <= 32'd0;
            hostReadData <= 32'd0;
        end else begin
            popData      <= w_popWord[r_sel][31:0];
            hostReadData <= w_hostWord[~r_sel][31:0];
        end
    end

`ifdef PING_PONG_PARITY_EN
    // Even parity over data plus stored parity bit must be zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            popParityError  <= 1'b0;
            hostParityError <= 1'b0;
        end else begin
            popParityError  <= ^w_popWord[r_sel];
            hostParityError <= ^w_hostWord[~r_sel];
        end
    end
`endif

    assign w_clampedCount = (hostWordCount > c_DEPTH_COUNT) ? c_DEPTH_COUNT : hostWordCount;

    // Commit/ready control state and bank-select register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_sel          <= 1'b0;
            r_pendingCount <= '0;
            r_dmaWordCount <= '0;
            r_hostOverrun  <= 1'b0;
        end else begin
            r_state        <= w_nextState;
            r_sel          <= w_nextSel;
            r_pendingCount <= w_nextPendingCount;
            r_dmaWordCount <= w_nextDmaWordCount;
            r_hostOverrun  <= w_nextHostOverrun;
        end
    end

    // Next-state logic: a switch always wins and hands the committed count over.
    always_comb begin
        w_nextState        = r_state;
        w_nextSel          = r_sel;
        w_nextPendingCount = r_pendingCount;
        w_nextDmaWordCount = r_dmaWordCount;
        w_nextHostOverrun  = 1'b0;
        if (switch) begin
            w_nextSel          = ~r_sel;
            w_nextDmaWordCount = hostCommit ? w_clampedCount : r_pendingCount;
            w_nextState        = c_ST_IDLE;
        end else if (hostCommit) begin
            if (r_state == c_ST_IDLE) begin
                w_nextPendingCount = w_clampedCount;
                w_nextState        = c_ST_READY;
            end else begin
                w_nextHostOverrun  = 1'b1;
            end
        end
    end

    assign dataReady    = (r_state == c_ST_READY);
    assign dmaWordCount = r_dmaWordCount;
    assign hostOverrun  = r_hostOverrun;

endmodule
`default_nettype wire

// File: tb/tb_ping_pong_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ping_pong_buffer
//  Description : Scoreboard bench for ping_pong_buffer. The driver applies a
//                directed sequence then random traffic, predicting outputs
//                with a bank-array model; a monitor compares each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ping_pong_buffer;

    localparam int DEPTH     = 256;
    localparam int ADDR_BITS = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pushAddress, pushData, popAddress, popData;
    logic        push, switch, dataReady;
    logic [8:0]  dmaWordCount;
    logic [7:0]  hostAddress;
    logic [31:0] hostWriteData, hostReadData;
    logic        hostWrite, hostCommit, hostOverrun;
    logic [8:0]  hostWordCount;
`ifdef PING_PONG_PARITY_EN
    logic        popParityError, hostParityError;
`endif

    ping_pong_buffer #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clock(clock), .reset(reset),
        .pushAddress(pushAddress), .pushData(pushData), .push(push),
        .popAddress(popAddress), .popData(popData),
        .switch(switch), .dataReady(dataReady), .dmaWordCount(dmaWordCount),
        .hostAddress(hostAddress), .hostWriteData(hostWriteData),
        .hostWrite(hostWrite), .hostReadData(hostReadData),
        .hostCommit(hostCommit), .hostWordCount(hostWordCount),
        .hostOverrun(hostOverrun)
`ifdef PING_PONG_PARITY_EN
        , .popParityError(popParityError), .hostParityError(hostParityError)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        push;
        logic [31:0] pushAddress;
        logic [31:0] pushData;
        logic [31:0] popAddress;
        logic        sw;
        logic        hw;
        logic [7:0]  hAddr;
        logic [31:0] hwd;
        logic        commit;
        logic [8:0]  count;
    } stim_t;

    typedef struct {
        logic [31:0] pop;
        bit          popKnown;
        logic [31:0] host;
        bit          hostKnown;
        logic        ready;
        logic [8:0]  dmaCount;
        logic        overrun;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: bank contents with known-flags, plus handshake state.
    logic [31:0] mBank  [2][DEPTH];
    bit          mValid [2][DEPTH];
    int          mSel, mPending, mDmaCount;
    bit          mReady;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s.rst = 0; s.push = 0; s.pushAddress = 0; s.pushData = 0; s.popAddress = 0;
        s.sw = 0; s.hw = 0; s.hAddr = 0; s.hwd = 0; s.commit = 0; s.count = 0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        int   pIdx, clamp;
        @(negedge clock);
        reset = s.rst; push = s.push; pushAddress = s.pushAddress; pushData = s.pushData;
        popAddress = s.popAddress; switch = s.sw; hostWrite = s.hw; hostAddress = s.hAddr;
        hostWriteData = s.hwd; hostCommit = s.commit; hostWordCount = s.count;
        if (s.rst) begin
            e = '{pop: 32'd0, popKnown: 1, host: 32'd0, hostKnown: 1,
                  ready: 0, dmaCount: 9'd0, overrun: 0};
            mSel = 0; mReady = 0; mPending = 0; mDmaCount = 0;
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < DEPTH; a++) mValid[b][a] = 0;
        end else begin
            pIdx = int'(s.popAddress) % DEPTH;
            if (pIdx < 0) pIdx += DEPTH;
            pIdx = int'(s.popAddress & 32'(DEPTH - 1));
            e.pop       = mBank[mSel][pIdx];
            e.popKnown  = mValid[mSel][pIdx];
            e.host      = mBank[1 - mSel][s.hAddr];
            e.hostKnown = mValid[1 - mSel][s.hAddr];
            if (s.push) begin
                mBank[mSel][s.pushAddress & 32'(DEPTH - 1)]  = s.pushData;
                mValid[mSel][s.pushAddress & 32'(DEPTH - 1)] = 1;
            end
            if (s.hw) begin
                mBank[1 - mSel][s.hAddr]  = s.hwd;
                mValid[1 - mSel][s.hAddr] = 1;
            end
            clamp = (int'(s.count) > DEPTH) ? DEPTH : int'(s.count);
            e.overrun = 0;
            if (s.sw) begin
                mDmaCount = s.commit ? clamp : mPending;
                mSel      = 1 - mSel;
                mReady    = 0;
            end else if (s.commit) begin
                if (!mReady) begin
                    mPending = clamp;
                    mReady   = 1;
                end else begin
                    e.overrun = 1;
                end
            end
            e.ready    = mReady;
            e.dmaCount = 9'(mDmaCount);
        end
        expQ.push_back(e);
    endtask

    // Monitor: one expectation per driven cycle, sampled after the edge.
    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (e.popKnown)  chk("popData", popData, e.pop);
            if (e.hostKnown) chk("hostReadData", hostReadData, e.host);
            chk("dataReady", 32'(dataReady), 32'(e.ready));
            chk("dmaWordCount", 32'(dmaWordCount), 32'(e.dmaCount));
            chk("hostOverrun", 32'(hostOverrun), 32'(e.overrun));
`ifdef PING_PONG_PARITY_EN
            if (e.popKnown)  chk("popParityError", 32'(popParityError), 32'd0);
            if (e.hostKnown) chk("hostParityError", 32'(hostParityError), 32'd0);
`endif
        end
    end

    initial begin
        stim_t s;
        reset = 1; push = 0; pushAddress = 0; pushData = 0; popAddress = 0; switch = 0;
        hostWrite = 0; hostAddress = 0; hostWriteData = 0; hostCommit = 0; hostWordCount = 0;

        // Reset then idle
        s = idleStim(); s.rst = 1; drive(s); drive(s);
        s = idleStim(); drive(s); drive(s);

        // Host fills two words, commits, DMA switches and reads word 1
        s = idleStim(); s.hw = 1; s.hAddr = 0; s.hwd = 32'hA5A5A5A5; drive(s);
        s = idleStim(); s.hw = 1; s.hAddr = 1; s.hwd = 32'h12345678; drive(s);
        s = idleStim(); s.commit = 1; s.count = 9'd2; drive(s);
        s = idleStim(); drive(s);
        s = idleStim(); s.sw = 1; drive(s);
        s = idleStim(); s.popAddress = 32'd1; drive(s); drive(s);
        s.popAddress = 32'd0; drive(s);

        // DMA push with wrapping address, then host reads it after a switch
        s = idleStim(); s.push = 1; s.pushAddress = 32'h105; s.pushData = 32'hDEADBEEF; drive(s);
        s = idleStim(); s.sw = 1; drive(s);
        s = idleStim(); s.hAddr = 8'd5; drive(s); drive(s);

        // Second commit without switch overruns; switch delivers the first count
        s = idleStim(); s.commit = 1; s.count = 9'd4; drive(s);
        s = idleStim(); drive(s);
        s = idleStim(); s.commit = 1; s.count = 9'd7; drive(s);
        s = idleStim(); drive(s);
        s = idleStim(); s.sw = 1; drive(s);
        s = idleStim(); drive(s);

        // Commit and switch in the same cycle
        s = idleStim(); s.commit = 1; s.count = 9'd9; s.sw = 1; drive(s);
        s = idleStim(); drive(s);

        // Clamp of an oversize count
        s = idleStim(); s.commit = 1; s.count = 9'd300; drive(s);
        s = idleStim(); s.sw = 1; drive(s);
        s = idleStim(); s.commit = 1; s.count = 9'd256; s.sw = 1; drive(s);

        // Read-before-write on the DMA side at the same address
        s = idleStim(); s.push = 1; s.pushAddress = 32'd9; s.pushData = 32'h11110000;
        s.popAddress = 32'd9; drive(s);
        s.pushData = 32'h22220000; drive(s);
        s = idleStim(); s.popAddress = 32'd9; drive(s);

        // Commit then reset: mapping returns to bank 0 for the DMA
        s = idleStim(); s.commit = 1; s.count = 9'd3; drive(s);
        s = idleStim(); s.rst = 1; drive(s);
        s = idleStim(); s.hw = 1; s.hAddr = 0; s.hwd = 32'hCAFEF00D; drive(s);
        s = idleStim(); s.sw = 1; drive(s);
        s = idleStim(); s.popAddress = 32'h300; drive(s); drive(s);

        // Random traffic on a small address window so reads hit known words
        for (int i = 0; i < 3000; i++) begin
            s = idleStim();
            s.rst         = ($urandom_range(0, 199) == 0);
            s.push        = ($urandom_range(0, 1) == 1);
            s.pushAddress = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
            s.pushData    = $urandom();
            s.popAddress  = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
            s.sw          = ($urandom_range(0, 9) == 0);
            s.hw          = ($urandom_range(0, 1) == 1);
            s.hAddr       = 8'($urandom_range(0, 15));
            s.hwd         = $urandom();
            s.commit      = ($urandom_range(0, 7) == 0);
            s.count       = 9'($urandom_range(0, 511));
            drive(s);
        end
        s = idleStim(); drive(s); drive(s);

        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge clock);
        #2;
        if (expQ.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ping_pong_buffer.md
Name: ping_pong_buffer

Overview:
- Dual-bank word buffer sitting directly between the DMA and the JTAG-side host logic.
- The DMA pushes and pops 32-bit words in one bank while the host fills or drains the other bank.
- A DMA-issued switch swaps the banks.
- The block raises dataReady toward the DMA once the host commits a filled bank, and hands over the committed word count.

Parameters:
- DEPTH, 256, words per bank; power of two.
- ADDR_BITS, 8, log2(DEPTH); used for host address and internal indexing.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- pushAddress  in  32  DMA write word index; only bits [ADDR_BITS-1:0] used, upper bits ignored (wrap).
- pushData  in  32  DMA write data.
- push  in  1  DMA write strobe, one word per cycle.
- popAddress  in  32  DMA read word index; only low ADDR_BITS bits used.
- popData  out  32  DMA read data, registered.
- switch  in  1  single-cycle pulse from DMA to swap banks.
- dataReady  out  1  host has committed a bank not yet taken by the DMA.
- dmaWordCount  out  ADDR_BITS+1  word count of the bank currently owned by the DMA.
- hostAddress  in  ADDR_BITS  host word index.
- hostWriteData  in  32  host write data.
- hostWrite  in  1  host write strobe.
- hostReadData  out  32  host read data, registered.
- hostCommit  in  1  single-cycle pulse: host bank filled.
- hostWordCount  in  ADDR_BITS+1  words valid in committed bank; 0..DEPTH.
- hostOverrun  out  1  one-cycle pulse: commit rejected.

Behaviour:
- Storage: two banks of DEPTH x 32.
  - Register sel: the DMA side accesses bank sel; the host side accesses bank ~sel.
- Reset: sel=0, dataReady=0, dmaWordCount=0, pendingCount=0, popData=0, hostReadData=0, hostOverrun=0. Memory contents are undefined.
- Reads: popData <= bank[sel][popAddress] every cycle; hostReadData <= bank[~sel][hostAddress] every cycle.
  - Latency is 1 cycle; no read enable.
- Writes: push writes bank[sel][pushAddress]; hostWrite writes bank[~sel][hostAddress].
  - The banks are distinct, so both may write in the same cycle.
- Same-side read and write to the same address in the same cycle: read-before-write; the read returns the old data.
- Accesses in the cycle switch is asserted use the pre-switch sel. The new mapping is effective from the next cycle.
- Commit/ready state, two states: IDLE (dataReady=0) and READY (dataReady=1).
  - IDLE & hostCommit: pendingCount <= hostWordCount; go to READY.
  - READY & hostCommit & !switch: commit ignored; pendingCount unchanged; hostOverrun=1 for one cycle.
  - switch (any state): sel <= ~sel; dmaWordCount <= hostCommit ? hostWordCount : pendingCount; go to IDLE.
  - switch & hostCommit same cycle: the committed bank is the one being handed to the DMA; dataReady ends 0; no overrun.
  - switch in IDLE with no commit: banks still swap; dmaWordCount <= pendingCount (stale). It is the DMA's responsibility to check dataReady first.
- hostWordCount > DEPTH: clamp to DEPTH when latched.
- dmaWordCount and dataReady change one cycle after the triggering edge (registered outputs).
- Reset mid-operation: all registers return to reset values in the next cycle; bank mapping reverts to sel=0.

Optional Feature:
- Macro PING_PONG_PARITY_EN.
- When defined:
  - Each stored word carries an even-parity bit computed on write.
  - New output popParityError (1 bit): registered alongside popData, high when the parity of the read word mismatches.
  - New output hostParityError (1 bit): the same, alongside hostReadData.
  - Both reset to 0.
- When undefined: no parity storage and no extra ports; behaviour is otherwise identical.

Test Plan:
- Reset, then idle -> dataReady=0, dmaWordCount=0, popData=0, hostOverrun=0.
- Host writes 0xA5A5A5A5 at addr 0 and 0x12345678 at addr 1, commits count=2 -> dataReady=1 next cycle. Switch -> dataReady=0, dmaWordCount=2. popAddress=1 -> popData=0x12345678 one cycle later.
- DMA pushes 0xDEADBEEF at pushAddress=0x105 (DEPTH=256) -> stored at index 5. Switch -> host reads addr 5, hostReadData=0xDEADBEEF.
- Commit count=4, then commit count=7 without a switch -> hostOverrun pulses once. Switch -> dmaWordCount=4.
- hostCommit count=9 and switch in the same cycle -> dmaWordCount=9, dataReady=0, hostOverrun=0, sel toggled.
- Commit then assert reset for one cycle -> dataReady=0, dmaWordCount=0, sel=0 (host write to addr 0 lands in bank 1, visible to DMA after one switch).
